// File: rtl/fp_operand_loader.sv
// Input stage for the FP16 multiplier: synchronises switches and buttons, debounces the
// buttons, and sequences capture of operands A and B into a valid/ready hand-off.
module fp_operand_loader #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             btn_save,
    input  logic             btn_clear,
    input  logic             op_ready,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    output logic [WIDTH-1:0] display,
    output logic [1:0]       phase
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        ISSUE = 2'b10,
        SHOW  = 2'b11
    } state_t;

    logic [WIDTH-1:0] r_sw_meta;
    logic [WIDTH-1:0] r_sw_sync;
    logic [1:0]       r_btn_meta;
    logic [1:0]       r_btn_sync;
    logic [1:0]       w_btn_raw;
    logic [1:0]       w_pulse;
    logic             w_save_p;
    logic             w_clear_p;

    assign w_btn_raw = {btn_clear, btn_save};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= sw_in;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= w_btn_raw;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Bit 0 is SAVE, bit 1 is CLEAR. The counter only runs while the synced level
    // disagrees with the accepted level, so any bounce back restarts the count.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic [CW-1:0] r_cnt;
            logic          r_db;
            logic          r_db_prev;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt     <= '0;
                    r_db      <= 1'b0;
                    r_db_prev <= 1'b0;
                end else begin
                    r_db_prev <= r_db;
                    if (r_btn_sync[gi] == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_db  <= r_btn_sync[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_pulse[gi] = r_db & ~r_db_prev;
        end
    endgenerate

    assign w_save_p  = w_pulse[0];
    assign w_clear_p = w_pulse[1];

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] w_op_a_next;
    logic [WIDTH-1:0] w_op_b_next;
    logic             r_op_valid;
    logic             w_op_valid_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= GET_A;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_op_a     <= w_op_a_next;
            r_op_b     <= w_op_b_next;
            r_op_valid <= w_op_valid_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_op_a_next     = r_op_a;
        w_op_b_next     = r_op_b;
        w_op_valid_next = r_op_valid;
        if (w_clear_p) begin
            w_state_next    = GET_A;
            w_op_a_next     = '0;
            w_op_b_next     = '0;
            w_op_valid_next = 1'b0;
        end else begin
            case (r_state)
                GET_A: if (w_save_p) begin
                    w_op_a_next  = r_sw_sync;
                    w_state_next = GET_B;
                end
                GET_B: if (w_save_p) begin
                    w_op_b_next     = r_sw_sync;
                    w_op_valid_next = 1'b1;
                    w_state_next    = ISSUE;
                end
                ISSUE: if (op_ready) begin
                    w_op_valid_next = 1'b0;
                    w_state_next    = SHOW;
                end
                SHOW: if (w_save_p) begin
                    w_state_next = GET_A;
                end
                default: w_state_next = GET_A;
            endcase
        end
    end

    always_comb begin
        display = r_sw_sync;
        case (r_state)
            ISSUE:   display = r_op_b;
            SHOW:    display = result;
            default: display = r_sw_sync;
        endcase
    end

    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_valid = r_op_valid;
    assign phase    = r_state;
endmodule

// File: tb/tb_fp_operand_loader.sv
// Randomised scoreboard bench for fp_operand_loader: a phase-level model predicts every
// state change, and a monitor process compares each observed change against the queue.
module tb_fp_operand_loader;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_in;
    logic        btn_save;
    logic        btn_clear;
    logic        op_ready;
    logic [15:0] result;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic [15:0] display;
    logic [1:0]  phase;

    always #5 clk = ~clk;

    fp_operand_loader #(.WIDTH(16), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .btn_save(btn_save), .btn_clear(btn_clear),
        .op_ready(op_ready), .result(result), .op_a(op_a), .op_b(op_b),
        .op_valid(op_valid), .display(display), .phase(phase)
    );

    // Simplified FP16 multiplier: normals only, truncating, flush to zero, clamp to inf.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] p;
        logic [9:0]  m;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        if (e <= 0) return {s, 15'd0};
        if (e >= 31) return {s, 5'h1f, 10'd0};
        return {s, e[4:0], m};
    endfunction

    assign result = fp16_mul(op_a, op_b);

    typedef struct packed {
        logic [1:0]  ph;
        logic [15:0] a;
        logic [15:0] b;
        logic        v;
        logic [15:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [1:0]  m_phase;
    logic [15:0] m_a;
    logic [15:0] m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] ph, input logic v);
        exp_t e;
        e.ph = ph;
        e.a  = m_a;
        e.b  = m_b;
        e.v  = v;
        e.d  = (ph < 2) ? sw_in : (ph == 2) ? m_b : fp16_mul(m_a, m_b);
        exp_q.push_back(e);
    endtask

    task automatic model_save();
        case (m_phase)
            2'd0: begin m_a = sw_in; m_phase = 2'd1; push(2'd1, 1'b0); end
            2'd1: begin
                m_b = sw_in; m_phase = 2'd2; push(2'd2, 1'b1);
                if (op_ready) begin m_phase = 2'd3; push(2'd3, 1'b0); end
            end
            2'd2: ;
            default: begin m_phase = 2'd0; push(2'd0, 1'b0); end
        endcase
    endtask

    task automatic model_clear();
        m_a = 16'd0;
        m_b = 16'd0;
        if (m_phase != 2'd0) push(2'd0, 1'b0);
        m_phase = 2'd0;
    endtask

    // Hold the buttons, then wait out the release debounce; returns op_valid-high cycles seen.
    task automatic press(input logic s, input logic c, input int hold, output int vcnt);
        vcnt = 0;
        btn_save  = s;
        btn_clear = c;
        repeat (hold) begin
            @(negedge clk);
            vcnt += int'(op_valid);
        end
        btn_save  = 1'b0;
        btn_clear = 1'b0;
        repeat (DC + 8) begin
            @(negedge clk);
            vcnt += int'(op_valid);
        end
    endtask

    task automatic glitch(input int k);
        btn_save = 1'b1;
        repeat (k) @(negedge clk);
        btn_save = 1'b0;
        repeat (DC + 8) @(negedge clk);
    endtask

    initial begin
        int vc;
        rst = 1'b1; sw_in = 16'd0; btn_save = 1'b0; btn_clear = 1'b0; op_ready = 1'b0;
        m_phase = 2'd0; m_a = 16'd0; m_b = 16'd0;
        #3;
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_op_a", 32'(op_a), 32'd0);
        check("reset_op_b", 32'(op_b), 32'd0);
        check("reset_valid", 32'(op_valid), 32'd0);
        check("reset_display", 32'(display), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        fork
            begin : monitor
                logic [1:0]  prev_ph;
                logic [15:0] iss_a;
                logic [15:0] iss_b;
                exp_t        e;
                prev_ph = 2'd0;
                iss_a   = 16'd0;
                iss_b   = 16'd0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_ph = 2'd0;
                    end else begin
                        if (phase != prev_ph) begin
                            if (exp_q.size() == 0) begin
                                tests++;
                                fails++;
                                $display("FAIL unexpected_transition: got phase %0d, expected phase %0d", phase, prev_ph);
                            end else begin
                                e = exp_q.pop_front();
                                check("mon_phase", 32'(phase), 32'(e.ph));
                                check("mon_op_a", 32'(op_a), 32'(e.a));
                                check("mon_op_b", 32'(op_b), 32'(e.b));
                                check("mon_valid", 32'(op_valid), 32'(e.v));
                                check("mon_display", 32'(display), 32'(e.d));
                                if (e.ph == 2'd2) begin iss_a = e.a; iss_b = e.b; end
                            end
                        end else if (op_valid) begin
                            check("stable_op_a", 32'(op_a), 32'(iss_a));
                            check("stable_op_b", 32'(op_b), 32'(iss_b));
                        end
                        prev_ph = phase;
                    end
                end
            end
        join_none

        // Directed: capture 1.0 and 2.0, hold off the multiplier, then accept.
        @(negedge clk);
        sw_in = 16'h3C00;
        repeat (4) @(negedge clk);
        model_save();
        press(1'b1, 1'b0, DC + 6, vc);
        check("a_captured", 32'(op_a), 32'h3C00);
        check("phase_get_b", 32'(phase), 32'd1);
        sw_in = 16'h4000;
        repeat (4) @(negedge clk);
        model_save();
        press(1'b1, 1'b0, DC + 6, vc);
        check("display_issue", 32'(display), 32'h4000);
        repeat (10) begin
            @(negedge clk);
            check("valid_held", 32'(op_valid), 32'd1);
        end
        m_phase = 2'd3;
        push(2'd3, 1'b0);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        check("valid_dropped", 32'(op_valid), 32'd0);
        check("display_result", 32'(display), 32'h4000);

        // Bounce every 2 cycles must not produce a pulse.
        for (int i = 0; i < 10; i++) begin
            btn_save = ~btn_save;
            repeat (2) @(negedge clk);
        end
        btn_save = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_no_pulse", 32'(phase), 32'd3);

        // Long hold: exactly one step SHOW -> GET_A.
        model_save();
        press(1'b1, 1'b0, 1000, vc);
        check("held_one_pulse", 32'(phase), 32'd0);

        // Randomised rounds.
        for (int r = 0; r < 8; r++) begin
            int dly;
            dly = $urandom_range(0, 4);
            sw_in = 16'($urandom);
            op_ready = 1'($urandom);
            repeat (4) @(negedge clk);
            glitch($urandom_range(1, 2));
            model_save();
            press(1'b1, 1'b0, DC + 6, vc);
            sw_in = 16'($urandom);
            op_ready = (dly == 0);
            repeat (4) @(negedge clk);
            model_save();
            press(1'b1, 1'b0, DC + 6, vc);
            if (dly == 0) begin
                check("valid_one_cycle", 32'(vc), 32'd1);
            end else begin
                if (dly[0]) press(1'b1, 1'b0, DC + 6, vc);
                repeat (dly) @(negedge clk);
                m_phase = 2'd3;
                push(2'd3, 1'b0);
                op_ready = 1'b1;
                @(negedge clk);
                check("accept_valid_low", 32'(op_valid), 32'd0);
            end
            check("round_show", 32'(phase), 32'd3);
            op_ready = 1'b0;
            if (r % 3 == 2) begin
                model_clear();
                press(1'b0, 1'b1, DC + 6, vc);
                check("clear_op_a", 32'(op_a), 32'd0);
            end else begin
                model_save();
                press(1'b1, 1'b0, DC + 6, vc);
            end
            check("round_get_a", 32'(phase), 32'd0);
        end

        // Simultaneous save and clear while in ISSUE: clear wins.
        op_ready = 1'b0;
        sw_in = 16'h3E00;
        repeat (4) @(negedge clk);
        model_save();
        press(1'b1, 1'b0, DC + 6, vc);
        sw_in = 16'hC000;
        repeat (4) @(negedge clk);
        model_save();
        press(1'b1, 1'b0, DC + 6, vc);
        check("issue_before_clear", 32'(phase), 32'd2);
        model_clear();
        press(1'b1, 1'b1, DC + 6, vc);
        check("both_phase", 32'(phase), 32'd0);
        check("both_op_a", 32'(op_a), 32'd0);
        check("both_op_b", 32'(op_b), 32'd0);
        check("both_valid", 32'(op_valid), 32'd0);

        // Asynchronous reset in GET_B mid-debounce.
        sw_in = 16'hC500;
        repeat (4) @(negedge clk);
        model_save();
        press(1'b1, 1'b0, DC + 6, vc);
        check("pre_rst_op_a", 32'(op_a), 32'hC500);
        sw_in = 16'h1234;
        btn_save = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_phase", 32'(phase), 32'd0);
        check("async_op_a", 32'(op_a), 32'd0);
        check("async_op_b", 32'(op_b), 32'd0);
        check("async_valid", 32'(op_valid), 32'd0);
        check("async_display", 32'(display), 32'd0);
        btn_save = 1'b0;
        m_phase = 2'd0; m_a = 16'd0; m_b = 16'd0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_phase", 32'(phase), 32'd0);
        check("post_rst_op_a", 32'(op_a), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
